// File: rtl/spike_event_aggregator.sv
// Fuses four per-sample detector flags into timestamped spike events queued in a FWFT FIFO.
// Optional: define SPIKE_AGG_RETRIGGER_EN to let flags during refractory restart the refractory count.
module spike_event_aggregator #(
    parameter int unsigned WINDOW     = 4,
    parameter int unsigned MIN_VOTES  = 2,
    parameter int unsigned REFRACT    = 16,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     data_in,
    input  logic            spike_neo,
    input  logic            spike_ado,
    input  logic            spike_aso,
    input  logic            spike_ed,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W-1:0] evt_ts,
    output logic [3:0]      evt_mask,
    output logic [2:0]      evt_votes,
    output logic [15:0]     evt_peak,
    output logic [15:0]     drop_count
);

    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned WCW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned RCW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int unsigned WLOAD = (WINDOW >= 2) ? WINDOW - 2 : 0;

    typedef enum logic [1:0] {IDLE, COLLECT, REFR} state_t;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [3:0]      mask;
        logic [2:0]      votes;
        logic [15:0]     peak;
    } evt_t;

    state_t          state;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] onset_ts;
    logic [3:0]      mask;
    logic [15:0]     peak;
    logic [WCW-1:0]  wcnt;
    logic [RCW-1:0]  rcnt;

    logic [3:0]      flags;
    logic [15:0]     abs_val;
    logic [3:0]      cur_mask;
    logic [15:0]     cur_peak;
    logic [TS_W-1:0] cur_ts;
    logic [2:0]      votes;
    logic            decide;
    logic            accept;
    state_t          next_after;

    assign flags = {spike_ed, spike_aso, spike_ado, spike_neo};

    // -32768 has no positive counterpart in 16 bits, so it saturates.
    always_comb begin
        abs_val = data_in;
        if (data_in == 16'h8000)
            abs_val = 16'h7FFF;
        else if (data_in[15])
            abs_val = ~data_in + 16'd1;
    end

    // Decision sees the current cycle's flags and sample merged with the accumulated window.
    always_comb begin
        cur_mask = flags;
        cur_peak = abs_val;
        cur_ts   = ts;
        if (state == COLLECT) begin
            cur_mask = mask | flags;
            cur_peak = (peak > abs_val) ? peak : abs_val;
            cur_ts   = onset_ts;
        end
        votes = '0;
        for (int unsigned i = 0; i < 4; i++)
            votes = votes + {2'b00, cur_mask[i]};
        decide = 1'b0;
        if (state == IDLE && (|flags) && WINDOW == 1)
            decide = 1'b1;
        if (state == COLLECT && wcnt == '0)
            decide = 1'b1;
        accept     = decide && (32'(votes) >= MIN_VOTES);
        next_after = (accept && REFRACT != 0) ? REFR : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ts       <= '0;
            onset_ts <= '0;
            mask     <= '0;
            peak     <= '0;
            wcnt     <= '0;
            rcnt     <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            case (state)
                IDLE: begin
                    if (|flags) begin
                        onset_ts <= ts;
                        mask     <= flags;
                        peak     <= abs_val;
                        if (WINDOW == 1) begin
                            state <= next_after;
                            rcnt  <= RCW'(REFRACT);
                        end else begin
                            state <= COLLECT;
                            wcnt  <= WCW'(WLOAD);
                        end
                    end
                end
                COLLECT: begin
                    mask <= cur_mask;
                    peak <= cur_peak;
                    if (wcnt == '0) begin
                        state <= next_after;
                        rcnt  <= RCW'(REFRACT);
                    end else begin
                        wcnt <= wcnt - WCW'(1);
                    end
                end
                REFR: begin
`ifdef SPIKE_AGG_RETRIGGER_EN
                    if (|flags)
                        rcnt <= RCW'(REFRACT);
                    else if (rcnt == RCW'(1))
                        state <= IDLE;
                    else
                        rcnt <= rcnt - RCW'(1);
`else
                    if (rcnt == RCW'(1))
                        state <= IDLE;
                    else
                        rcnt <= rcnt - RCW'(1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    evt_t          mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    evt_t          head;

    assign pop     = (count != '0) && evt_ready;
    assign full    = (count == (PW + 1)'(FIFO_DEPTH));
    assign push_ok = accept && (!full || pop);
    assign drop    = accept && !push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{ts: cur_ts, mask: cur_mask, votes: votes, peak: cur_peak};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_ts    = evt_valid ? head.ts    : '0;
    assign evt_mask  = evt_valid ? head.mask  : '0;
    assign evt_votes = evt_valid ? head.votes : '0;
    assign evt_peak  = evt_valid ? head.peak  : '0;

endmodule

// File: tb/tb_spike_event_aggregator.sv
// Self-checking bench for spike_event_aggregator: directed table, corner sequences, and a
// randomized run against a time-based event model.
module tb_spike_event_aggregator;

    localparam int W  = 4;
    localparam int MV = 2;
    localparam int R  = 16;
    localparam int D  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        spike_neo = 1'b0, spike_ado = 1'b0, spike_aso = 1'b0, spike_ed = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [31:0] evt_ts;
    logic [3:0]  evt_mask;
    logic [2:0]  evt_votes;
    logic [15:0] evt_peak;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    spike_event_aggregator #(
        .WINDOW(W), .MIN_VOTES(MV), .REFRACT(R), .TS_W(32), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .spike_neo(spike_neo), .spike_ado(spike_ado), .spike_aso(spike_aso), .spike_ed(spike_ed),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_mask(evt_mask),
        .evt_votes(evt_votes), .evt_peak(evt_peak), .drop_count(drop_count)
    );

    typedef struct {
        int unsigned ts;
        logic [3:0]  mask;
        int          votes;
        int          peak;
    } ev_t;

    // Model: absolute-time bookkeeping of window onset and the time the block is next idle.
    int unsigned mts, monset, midle_at;
    bit          mopen, model_ok;
    logic [3:0]  mmask;
    int          mpeak, mdrop;
    ev_t         mq[$];
    int unsigned seen[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int absv(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int pop4(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (model ts %0d)", name, act, exp, mts);
        end
    endtask

    task automatic model_reset();
        mts = 0; monset = 0; midle_at = 0; mopen = 0; mmask = '0; mpeak = 0; mdrop = 0;
        mq.delete();
        model_ok = 1;
    endtask

    task automatic model_cycle(input logic [3:0] f, input logic [15:0] d, input logic rdy);
        bit  pushp = 0;
        bit  popv;
        ev_t pe;
        popv = (mq.size() > 0) && rdy;
        if (mopen) begin
            mmask |= f;
            if (absv(d) > mpeak) mpeak = absv(d);
            if (mts == monset + W - 1) begin
                mopen = 0;
                if (pop4(mmask) >= MV) begin
                    pushp = 1;
                    midle_at = monset + W + R;
                end else begin
                    midle_at = mts + 1;
                end
            end
        end else if (mts < midle_at) begin
`ifdef SPIKE_AGG_RETRIGGER_EN
            if (f != 0) midle_at = mts + 1 + R;
`endif
        end else if (f != 0) begin
            monset = mts;
            mmask  = f;
            mpeak  = absv(d);
            mopen  = 1;
        end
        pe.ts = monset; pe.mask = mmask; pe.votes = pop4(mmask); pe.peak = mpeak;
        if (popv) void'(mq.pop_front());
        if (pushp) begin
            if (mq.size() < D) mq.push_back(pe);
            else if (mdrop < 65535) mdrop++;
        end
        mts++;
    endtask

    // One cycle: check outputs of the current cycle against the model, then drive this cycle's inputs.
    task automatic step(input logic [3:0] f, input logic [15:0] d, input logic rdy, input logic r);
        @(negedge clk);
        if (model_ok) begin
            chk("valid", 32'(evt_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("ts", evt_ts, mq[0].ts);
                chk("mask", 32'(evt_mask), 32'(mq[0].mask));
                chk("votes", 32'(evt_votes), 32'(mq[0].votes));
                chk("peak", 32'(evt_peak), 32'(mq[0].peak));
            end
            chk("drop", 32'(drop_count), 32'(mdrop));
        end
        if (evt_valid && rdy) seen.push_back(evt_ts);
        {spike_ed, spike_aso, spike_ado, spike_neo} = f;
        data_in   = d;
        evt_ready = rdy;
        rst       = r;
        if (r) model_reset();
        else model_cycle(f, d, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(4'b0000, 16'd0, rdy, 1'b0);
    endtask

    typedef struct {
        logic [3:0]  f0;
        logic [15:0] d0;
        logic [15:0] d2;
        logic [3:0]  f3;
        logic        ok;
        logic [3:0]  mask;
        logic [2:0]  votes;
        logic [15:0] peak;
    } vec_t;

    vec_t        tbl[6];
    int unsigned t;
    int unsigned onsets[10];

    initial begin
        tbl[0] = '{4'b0011, 16'hFB50, 16'd100, 4'b0000, 1'b1, 4'b0011, 3'd2, 16'd1200};
        tbl[1] = '{4'b0001, 16'd500,  16'd900, 4'b1000, 1'b1, 4'b1001, 3'd2, 16'd900};
        tbl[2] = '{4'b0001, 16'd300,  16'd0,   4'b0000, 1'b0, 4'b0000, 3'd0, 16'd0};
        tbl[3] = '{4'b1111, 16'h8000, 16'd5,   4'b0000, 1'b1, 4'b1111, 3'd4, 16'd32767};
        tbl[4] = '{4'b0100, 16'd1,    16'h7FFF, 4'b0100, 1'b0, 4'b0000, 3'd0, 16'd0};
        tbl[5] = '{4'b0010, 16'd7,    16'hFFF8, 4'b0100, 1'b1, 4'b0110, 3'd2, 16'd8};
        model_ok = 0;

        step(4'b0000, 16'd0, 1'b0, 1'b1);
        step(4'b0000, 16'd0, 1'b0, 1'b0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ts", evt_ts, 32'd0);
        chk("rst_mask", 32'(evt_mask), 32'd0);
        chk("rst_votes", 32'(evt_votes), 32'd0);
        chk("rst_peak", 32'(evt_peak), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        while (mts < 10) idle(1, 1'b0);

        // Table: onset at t, sample d2 at t+2, flags f3 at t+3; head examined in cycle t+4.
        for (int i = 0; i < 6; i++) begin
            t = mts;
            step(tbl[i].f0, tbl[i].d0, 1'b0, 1'b0);
            step(4'b0000, 16'd0, 1'b0, 1'b0);
            step(4'b0000, tbl[i].d2, 1'b0, 1'b0);
            step(tbl[i].f3, 16'd0, 1'b0, 1'b0);
            step(4'b0000, 16'd0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 32'(evt_valid), 32'(tbl[i].ok));
            if (tbl[i].ok) begin
                chk($sformatf("tbl%0d_ts", i), evt_ts, t);
                chk($sformatf("tbl%0d_mask", i), 32'(evt_mask), 32'(tbl[i].mask));
                chk($sformatf("tbl%0d_votes", i), 32'(evt_votes), 32'(tbl[i].votes));
                chk($sformatf("tbl%0d_peak", i), 32'(evt_peak), 32'(tbl[i].peak));
            end
            idle(R + 2, 1'b1);
        end

        // Rejected single-detector window; a flag in the very next cycle opens a new one.
        t = mts;
        step(4'b0001, 16'd10, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(4'b1000, 16'd20, 1'b0, 1'b0);
        step(4'b0010, 16'd30, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(4'b0000, 16'd0, 1'b1, 1'b0);
        chk("rewin_valid", 32'(evt_valid), 32'd1);
        chk("rewin_ts", evt_ts, t + 4);
        chk("rewin_mask", 32'(evt_mask), 32'(4'b1010));
        idle(R + 2, 1'b1);

        // Bursts at t, t+10, t+20 against the refractory period.
        seen.delete();
        t = mts;
        step(4'b1111, 16'd100, 1'b1, 1'b0);
        idle(9, 1'b1);
        step(4'b1111, 16'd100, 1'b1, 1'b0);
        idle(9, 1'b1);
        step(4'b1111, 16'd100, 1'b1, 1'b0);
        idle(30, 1'b1);
`ifdef SPIKE_AGG_RETRIGGER_EN
        chk("burst_count", seen.size(), 32'd1);
`else
        chk("burst_count", seen.size(), 32'd2);
        if (seen.size() == 2) chk("burst_ts1", seen[1], t + 20);
`endif
        if (seen.size() > 0) chk("burst_ts0", seen[0], t);

        // Overflow: 10 accepted events with backpressure, then drain.
        for (int k = 0; k < 10; k++) begin
            onsets[k] = mts;
            step(4'b1111, 16'(k * 10), 1'b0, 1'b0);
            idle(W + R - 1, 1'b0);
        end
        chk("ovf_drop", 32'(drop_count), 32'd2);
        chk("ovf_valid", 32'(evt_valid), 32'd1);
        seen.delete();
        idle(8, 1'b1);
        step(4'b0000, 16'd0, 1'b1, 1'b0);
        chk("drain_empty", 32'(evt_valid), 32'd0);
        chk("drain_count", seen.size(), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < seen.size()) chk($sformatf("drain_ts%0d", k), seen[k], onsets[k]);

        // Peak saturation for -32768, then reset in the middle of a window.
        step(4'b0001, 16'h8000, 1'b1, 1'b0);
        step(4'b0010, 16'd0, 1'b1, 1'b0);
        idle(2, 1'b1);
        step(4'b0000, 16'd0, 1'b0, 1'b0);
        chk("sat_valid", 32'(evt_valid), 32'd1);
        chk("sat_peak", 32'(evt_peak), 32'd32767);
        idle(R + 2, 1'b1);
        step(4'b1111, 16'd5, 1'b1, 1'b0);
        step(4'b0000, 16'd0, 1'b1, 1'b0);
        step(4'b0000, 16'd0, 1'b1, 1'b1);
        step(4'b0011, 16'd10, 1'b0, 1'b0);
        chk("midrst_valid", 32'(evt_valid), 32'd0);
        chk("midrst_drop", 32'(drop_count), 32'd0);
        idle(3, 1'b0);
        step(4'b0000, 16'd0, 1'b1, 1'b0);
        chk("midrst_newvalid", 32'(evt_valid), 32'd1);
        chk("midrst_newts", evt_ts, 32'd0);
        idle(R + 2, 1'b1);

        // Randomized traffic with sparse flags, random backpressure and occasional reset.
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] f;
            for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 9) == 0);
            step(f, 16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 799) == 0));
        end
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
